move_collector: RTL and testbench

//  Downstream drain stage for the eight columnUnit instances of the move generator.

---
 rtl/move_collector.sv | 158 +++++++++++++++
 tb/tb_move_collector.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_collector.sv
// Drains eight column move FIFOs round-robin onto one valid/ready stream,
// tagging each record with its column and flagging board completion.
module move_collector #(
    parameter int NCOL  = 8,
    parameter int DW    = 160,
    parameter int RDLAT = 1,
    parameter int CW    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [NCOL-1:0]    colDone,
    input  logic [NCOL-1:0]    fifoEmpty,
    input  logic [NCOL*DW-1:0] fifoOut,
    output logic [NCOL-1:0]    rden,
    output logic [DW-1:0]      move_data,
    output logic [2:0]         move_col,
    output logic               move_valid,
    input  logic               move_ready,
    output logic [CW-1:0]      move_count,
    output logic               busy,
    output logic               all_done
);

    localparam int WCW = (RDLAT > 1) ? $clog2(RDLAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_READ,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t          r_state, w_state;
    logic [2:0]      r_ptr, w_ptr;
    logic [NCOL-1:0] r_rden, w_rden;
    logic [DW-1:0]   r_data, w_data;
    logic [2:0]      r_col, w_col;
    logic            r_valid, w_valid;
    logic [CW-1:0]   r_count, w_count;
    logic            r_busy, w_busy;
    logic            r_done, w_done;
    logic [WCW-1:0]  r_wcnt, w_wcnt;

    logic            w_found;
    logic [2:0]      w_g;
    logic [2:0]      w_idx;

    // First non-empty column after the last grant, wrapping past NCOL-1.
    always_comb begin
        w_found = 1'b0;
        w_g     = r_ptr;
        w_idx   = '0;
        for (int i = 1; i <= NCOL; i++) begin
            w_idx = 3'((int'(r_ptr) + i) % NCOL);
            if (!w_found && !fifoEmpty[w_idx]) begin
                w_found = 1'b1;
                w_g     = w_idx;
            end
        end
    end

    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_rden  = '0;
        w_data  = r_data;
        w_col   = r_col;
        w_valid = r_valid;
        w_count = r_count;
        w_busy  = r_busy;
        w_done  = r_done;
        w_wcnt  = r_wcnt;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state = S_SCAN;
                    w_count = '0;
                    w_done  = 1'b0;
                    w_busy  = 1'b1;
                    w_ptr   = 3'(NCOL - 1);
                end
            end
            S_SCAN: begin
                if (w_found) begin
                    w_ptr       = w_g;
                    w_rden[w_g] = 1'b1;
                    w_state     = S_READ;
                end else if (&colDone) begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                end
            end
            S_READ: begin
                w_wcnt  = WCW'(RDLAT - 1);
                w_state = S_WAIT;
            end
            S_WAIT: begin
                if (r_wcnt == '0) begin
                    w_data  = fifoOut[DW*r_ptr +: DW];
                    w_col   = r_ptr;
                    w_valid = 1'b1;
                    w_state = S_HOLD;
                end else begin
                    w_wcnt = r_wcnt - 1'b1;
                end
            end
            S_HOLD: begin
                if (move_ready) begin
                    w_valid = 1'b0;
                    if (r_count != '1) begin
                        w_count = r_count + 1'b1;
                    end
                    w_state = S_SCAN;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ptr   <= 3'(NCOL - 1);
            r_rden  <= '0;
            r_data  <= '0;
            r_col   <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_rden  <= w_rden;
            r_data  <= w_data;
            r_col   <= w_col;
            r_valid <= w_valid;
            r_count <= w_count;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_wcnt  <= w_wcnt;
        end
    end

    assign rden       = r_rden;
    assign move_data  = r_data;
    assign move_col   = r_col;
    assign move_valid = r_valid;
    assign move_count = r_count;
    assign busy       = r_busy;
    assign all_done   = r_done;

endmodule

// File: tb/tb_move_collector.sv
// Directed bench for move_collector with a behavioural column-FIFO model.
module tb_move_collector;

    localparam int NCOL = 8;
    localparam int DW   = 160;
    localparam int CW   = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [NCOL-1:0]    colDone;
    logic [NCOL-1:0]    fifoEmpty;
    logic [NCOL*DW-1:0] fifoOut = '0;
    logic [NCOL-1:0]    rden;
    logic [DW-1:0]      move_data;
    logic [2:0]         move_col;
    logic               move_valid;
    logic               move_ready;
    logic [CW-1:0]      move_count;
    logic               busy;
    logic               all_done;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem [NCOL][8];
    int            wp  [NCOL] = '{default: 0};
    int            rp  [NCOL] = '{default: 0};

    logic [NCOL-1:0] rdlog [16];
    int              nrd = 0;

    move_collector #(.NCOL(NCOL), .DW(DW), .RDLAT(1), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .colDone   (colDone),
        .fifoEmpty (fifoEmpty),
        .fifoOut   (fifoOut),
        .rden      (rden),
        .move_data (move_data),
        .move_col  (move_col),
        .move_valid(move_valid),
        .move_ready(move_ready),
        .move_count(move_count),
        .busy      (busy),
        .all_done  (all_done)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int c = 0; c < NCOL; c++) begin
            fifoEmpty[c] = (wp[c] == rp[c]);
        end
    end

    // One-cycle read latency: data appears the cycle after the rden cycle.
    always @(posedge clk) begin
        for (int c = 0; c < NCOL; c++) begin
            if (rden[c]) begin
                fifoOut[c*DW +: DW] <= mem[c][rp[c] % 8];
                rp[c] <= rp[c] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rden != '0) begin
            rdlog[nrd % 16] <= rden;
            nrd <= nrd + 1;
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [DW-1:0] d);
        mem[c][wp[c] % 8] = d;
        wp[c] = wp[c] + 1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic get_move(input string tag, output logic [DW-1:0] d,
                            output logic [2:0] c);
        bit ok;
        ok = 1'b0;
        d  = '0;
        c  = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (move_valid) begin
                ok = 1'b1;
                d  = move_data;
                c  = move_col;
                break;
            end
        end
        chk({tag, "_arrive"}, DW'(ok), DW'(1));
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (all_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, DW'(ok), DW'(1));
    endtask

    logic [DW-1:0] d;
    logic [2:0]    c;
    int            base;
    logic [NCOL-1:0] rl;
    logic [DW-1:0] held;
    logic [2:0]    ord [6];

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        colDone    = '0;
        move_ready = 1'b1;
        ord        = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1};

        #23;
        chk("rst_rden", DW'(rden), DW'(0));
        chk("rst_valid", DW'(move_valid), DW'(0));
        chk("rst_data", move_data, '0);
        chk("rst_col", DW'(move_col), DW'(0));
        chk("rst_count", DW'(move_count), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_done", DW'(all_done), DW'(0));
        @(negedge clk);
        reset = 1'b1;

        // 1: cols 2 and 5, one entry each
        colDone = '1;
        push(2, {20{8'hA5}});
        push(5, {20{8'h3C}});
        base = nrd;
        pulse_start();
        chk("t1_busy", DW'(busy), DW'(1));
        get_move("t1_m0", d, c);
        chk("t1_col0", DW'(c), DW'(2));
        chk("t1_dat0", d, {20{8'hA5}});
        get_move("t1_m1", d, c);
        chk("t1_col1", DW'(c), DW'(5));
        chk("t1_dat1", d, {20{8'h3C}});
        wait_done("t1");
        chk("t1_count", DW'(move_count), DW'(2));
        chk("t1_busy_lo", DW'(busy), DW'(0));
        chk("t1_nrd", DW'(nrd - base), DW'(2));
        rl = rdlog[base % 16];
        chk("t1_rd0", DW'(rl), DW'(8'h04));
        rl = rdlog[(base + 1) % 16];
        chk("t1_rd1", DW'(rl), DW'(8'h20));

        // 2: cols 0 and 1, three entries each -> alternating
        for (int k = 0; k < 3; k++) begin
            push(0, DW'(16'h0000 + k));
            push(1, DW'(16'h0100 + k));
        end
        base = nrd;
        pulse_start();
        chk("t2_done_clr", DW'(all_done), DW'(0));
        for (int k = 0; k < 6; k++) begin
            get_move("t2_m", d, c);
            chk("t2_col", DW'(c), DW'(ord[k]));
            chk("t2_dat", d, DW'({5'd0, ord[k], 8'(k / 2)}));
        end
        wait_done("t2");
        chk("t2_count", DW'(move_count), DW'(6));
        for (int k = 0; k < 6; k++) begin
            rl = rdlog[(base + k) % 16];
            chk("t2_rd_onehot", DW'($onehot(rl)), DW'(1));
        end

        // 3: back-pressure in HOLD, then start while busy
        colDone    = '0;
        move_ready = 1'b0;
        push(3, {40{4'h9}});
        pulse_start();
        get_move("t3_m", d, c);
        chk("t3_col", DW'(c), DW'(3));
        held = d;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t3_hold_valid", DW'(move_valid), DW'(1));
            chk("t3_hold_data", move_data, held);
            chk("t3_hold_rden", DW'(rden), DW'(0));
        end
        chk("t3_cnt_pre", DW'(move_count), DW'(0));
        move_ready = 1'b1;
        @(negedge clk);
        chk("t3_valid_lo", DW'(move_valid), DW'(0));
        chk("t3_cnt_post", DW'(move_count), DW'(1));
        pulse_start();
        @(negedge clk);
        chk("t3_busy_start", DW'(move_count), DW'(1));
        chk("t3_busy", DW'(busy), DW'(1));
        chk("t3_not_done", DW'(all_done), DW'(0));
        colDone = '1;
        wait_done("t3");
        chk("t3_count", DW'(move_count), DW'(1));

        // 4: done flags set early, col 7 still drained
        push(7, DW'(32'hDEAD_0001));
        push(7, DW'(32'hDEAD_0002));
        pulse_start();
        get_move("t4_m0", d, c);
        chk("t4_col0", DW'(c), DW'(7));
        chk("t4_dat0", d, DW'(32'hDEAD_0001));
        chk("t4_early0", DW'(all_done), DW'(0));
        get_move("t4_m1", d, c);
        chk("t4_col1", DW'(c), DW'(7));
        chk("t4_dat1", d, DW'(32'hDEAD_0002));
        chk("t4_early1", DW'(all_done), DW'(0));
        wait_done("t4");
        chk("t4_count", DW'(move_count), DW'(2));

        // 5: asynchronous reset while holding a move
        move_ready = 1'b0;
        push(6, DW'(32'h6666_6666));
        pulse_start();
        get_move("t5_m", d, c);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rst_valid", DW'(move_valid), DW'(0));
        chk("t5_rst_data", move_data, '0);
        chk("t5_rst_col", DW'(move_col), DW'(0));
        chk("t5_rst_busy", DW'(busy), DW'(0));
        chk("t5_rst_rden", DW'(rden), DW'(0));
        chk("t5_rst_done", DW'(all_done), DW'(0));
        @(negedge clk);
        reset      = 1'b1;
        move_ready = 1'b1;
        push(4, DW'(32'h4444_0004));
        pulse_start();
        get_move("t5_m1", d, c);
        chk("t5_col", DW'(c), DW'(4));
        chk("t5_dat", d, DW'(32'h4444_0004));
        wait_done("t5");
        chk("t5_count", DW'(move_count), DW'(1));

        // 6: empty board completes in two cycles, twice
        base = nrd;
        pulse_start();
        chk("t6_busy", DW'(busy), DW'(1));
        chk("t6_done_lo", DW'(all_done), DW'(0));
        @(negedge clk);
        chk("t6_done", DW'(all_done), DW'(1));
        chk("t6_count", DW'(move_count), DW'(0));
        pulse_start();
        chk("t6_busy2", DW'(busy), DW'(1));
        chk("t6_done_lo2", DW'(all_done), DW'(0));
        @(negedge clk);
        chk("t6_done2", DW'(all_done), DW'(1));
        chk("t6_nrd", DW'(nrd - base), DW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
